// File: rtl/imem_line_server.sv
// imem_line_server: memory-side responder for the instruction cache line-fill port.
//
// A single-cycle request pulse carries a byte address. The addressed 16-byte line
// comes back LATENCY edges later as a one-cycle mem_ready_o pulse. Requests that
// arrive while the engine is busy wait in a small FIFO and are served one at a time.
// Program storage is a word array that is loaded through a backdoor write port.
//
// Optional feature macro: IMEM_LINE_ERR_EN
//   defined   : lines beyond DEPTH_WORDS return zero data with err_o=1 on the ready cycle
//   undefined : the word index wraps modulo DEPTH_WORDS and err_o is tied 0
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid_i  line-read request pulse
//   req_addr_i   byte address of the line (bits [3:0] ignored)
//   mem_ready_o  one-cycle response strobe
//   mem_data_o   128-bit line, lowest-addressed word in [31:0]
//   ld_we_i      backdoor word write enable
//   ld_addr_i    backdoor word index
//   ld_data_i    backdoor write data
//   busy_o       request queued or in service
//   ovf_o        sticky: a request was dropped on a full queue
//   err_o        out-of-range line, qualified by mem_ready_o
module imem_line_server #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_i,
  input  logic [31:0]  req_addr_i,
  output logic         mem_ready_o,
  output logic [127:0] mem_data_o,
  input  logic         ld_we_i,
  input  logic [31:0]  ld_addr_i,
  input  logic [31:0]  ld_data_i,
  output logic         busy_o,
  output logic         ovf_o,
  output logic         err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int QW = $clog2(FIFO_DEPTH);
  // A fresh request is sampled on its own edge, so LATENCY-1 further edges remain.
  localparam logic [3:0] CNT_ACC = 4'(LATENCY - 1);
  // A queued request popped on the edge after the previous ready edge has already
  // used one of its LATENCY edges, so it loads one less to keep readies L apart.
  localparam logic [3:0] CNT_POP = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [27:0]   cur_line, cur_line_nx;
  logic [27:0]   rd_line;
  logic          pop, push, drop, fire;

  logic [27:0]   q_mem [FIFO_DEPTH];
  logic [QW-1:0] q_rd, q_wr;
  logic [QW:0]   q_cnt;
  logic          q_full;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [29:0]   wbase;
  logic [AW-1:0] widx;
  logic [127:0]  line_data;

  assign q_full = (q_cnt == (QW+1)'(FIFO_DEPTH));
  assign busy_o = (state != IDLE) || (q_cnt != '0);

  // Next-state, queue control and the line to read on a firing edge
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cur_line_nx = cur_line;
    rd_line     = cur_line;
    pop         = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    fire        = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          cur_line_nx = req_addr_i[31:4];
          cnt_nx      = CNT_ACC;
          state_nx    = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          fire     = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
        if (req_valid_i) begin
          if (q_full) drop = 1'b1;
          else        push = 1'b1;
        end
      end
      RESP: begin
        if (q_cnt != '0) begin
          pop         = 1'b1;
          push        = req_valid_i;
          cur_line_nx = q_mem[q_rd];
          if (LATENCY == 1) begin
            // Single-edge latency: serve the popped entry right away, staying in RESP.
            rd_line = q_mem[q_rd];
            fire    = 1'b1;
          end else begin
            cnt_nx   = CNT_POP;
            state_nx = WAIT;
          end
        end else if (req_valid_i) begin
          cur_line_nx = req_addr_i[31:4];
          cnt_nx      = CNT_ACC;
          state_nx    = WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cur_line <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_line <= cur_line_nx;
    end
  end

  // Pending-request queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) q_wr <= q_wr + 1'b1;
      if (pop)  q_rd <= q_rd + 1'b1;
      q_cnt <= q_cnt + (QW+1)'(push) - (QW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= req_addr_i[31:4];
  end

  // Backdoor storage load; out-of-range indices are discarded
  always_ff @(posedge clk) begin
    if (ld_we_i && (ld_addr_i < 32'(DEPTH_WORDS))) mem[ld_addr_i[AW-1:0]] <= ld_data_i;
  end

  // Line read; the low index bits of wbase are zero so OR selects the word in the line
  assign wbase     = {rd_line, 2'b00};
  assign widx      = wbase[AW-1:0];
  assign line_data = {mem[widx | AW'(3)], mem[widx | AW'(2)],
                      mem[widx | AW'(1)], mem[widx]};

`ifdef IMEM_LINE_ERR_EN
  logic line_oob;
  logic err_q;
  assign line_oob = ({2'b00, wbase} >= 32'(DEPTH_WORDS));
  assign err_o    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_o <= 1'b0;
      mem_data_o  <= '0;
      err_q       <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      mem_ready_o <= fire;
      err_q       <= fire && line_oob;
      if (fire) mem_data_o <= line_oob ? '0 : line_data;
      if (drop) ovf_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_o <= 1'b0;
      mem_data_o  <= '0;
      ovf_o       <= 1'b0;
    end else begin
      mem_ready_o <= fire;
      if (fire) mem_data_o <= line_data;
      if (drop) ovf_o <= 1'b1;
    end
  end
`endif

endmodule
